// File: rtl/muldiv_pkg.sv
//==============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the multiply/divide sequencing control:
//               2-bit state encoding, iteration-counter width and default
//               RUN-phase lengths for multiply and divide.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package muldiv_pkg;

    // Width of the iteration counter; both cycle counts must fit in it.
    localparam int c_cnt_w = 6;

    // Default RUN-phase lengths.
    localparam int c_mul_cycles_dflt = 4;
    localparam int c_div_cycles_dflt = 32;

    // State encoding.
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_run  = 2'd1;
    localparam state_t c_st_done = 2'd2;

    typedef logic [c_cnt_w-1:0] cnt_t;
    localparam cnt_t c_cnt_zero = '0;
    localparam cnt_t c_cnt_one  = cnt_t'(1);

    // Counter load value for a RUN phase of n cycles (counts n-1 down to 0).
    function automatic cnt_t cycles_to_cnt(input int n);
        return cnt_t'(n - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
//==============================================================================
// Module      : muldiv_ctrl
// Description : Sequencing control for an iterative multiply/divide unit.
//               Accepts a mult/div from Execute, enables the iterative steps
//               for a fixed number of cycles, then pulses the HI/LO write
//               enable. Generates the stall request for dependent mfhi/mflo
//               or a second mult/div while an operation is in flight.
//               Optional macro MULDIV_DIV0_FAST_EN: a divide by zero skips
//               the RUN phase and reports div0 with the HI/LO write.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = c_mul_cycles_dflt,
    parameter int DIV_CYCLES = c_div_cycles_dflt
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mul0_div1_sel,
    input  logic opb_zero,
    input  logic hilo_rd,
    input  logic flushE,
    output logic op_load,
    output logic step_en,
    output logic hilo_we,
    output logic busy,
    output logic stall_md,
    output logic div0
);

    localparam cnt_t c_mul_load = cycles_to_cnt(MUL_CYCLES);
    localparam cnt_t c_div_load = cycles_to_cnt(DIV_CYCLES);

    state_t r_state;
    state_t w_state_nxt;
    cnt_t   r_cnt;
    cnt_t   w_cnt_nxt;
    logic   r_op_div;
    logic   w_op_div_nxt;
    logic   w_accept;
    logic   w_fast_div0;

    // A flushed instruction is never accepted, and reset wins over start.
    assign w_accept = (r_state == c_st_idle) && start && !flushE && !rst;

`ifdef MULDIV_DIV0_FAST_EN
    logic r_div0;
    logic w_div0_nxt;

    assign w_fast_div0 = mul0_div1_sel && opb_zero;

    // Remember that the operation in flight took the divide-by-zero shortcut.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div0 <= 1'b0;
        end else begin
            r_div0 <= w_div0_nxt;
        end
    end

    assign w_div0_nxt = w_accept ? w_fast_div0 :
                        (r_state == c_st_done) ? 1'b0 : r_div0;
    assign div0       = (r_state == c_st_done) && r_div0;
`else
    // Divide by zero runs the full divide; the flag is never raised.
    logic w_unused_opb_zero;
    assign w_unused_opb_zero = opb_zero;
    assign w_fast_div0       = 1'b0;
    assign div0              = 1'b0;
`endif

    // State, iteration counter and latched operation type.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= c_cnt_zero;
            r_op_div <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op_div <= w_op_div_nxt;
        end
    end

    // Next-state, counter update and per-state control outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_op_div_nxt = r_op_div;
        op_load      = 1'b0;
        step_en      = 1'b0;
        hilo_we      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    op_load      = 1'b1;
                    w_op_div_nxt = mul0_div1_sel;
                    w_cnt_nxt    = mul0_div1_sel ? c_div_load : c_mul_load;
                    w_state_nxt  = w_fast_div0 ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                step_en = 1'b1;
                if (r_cnt == c_cnt_zero) begin
                    w_state_nxt = c_st_done;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            c_st_done: begin
                hilo_we     = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign busy     = (r_state != c_st_idle);
    assign stall_md = busy && (hilo_rd || start);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
//==============================================================================
// Module      : tb_muldiv_ctrl
// Description : Randomized scoreboard bench for muldiv_ctrl. A timeline model
//               predicts each accepted operation's completion cycle; a monitor
//               pops expectations whenever the HI/LO write enable appears.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_muldiv_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;
`ifdef MULDIV_DIV0_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int N_CYC = 4000;

    logic clk = 1'b0;
    logic rst, start, mul0_div1_sel, opb_zero, hilo_rd, flushE;
    logic op_load, step_en, hilo_we, busy, stall_md, div0;

    muldiv_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst), .start(start), .mul0_div1_sel(mul0_div1_sel),
        .opb_zero(opb_zero), .hilo_rd(hilo_rd), .flushE(flushE),
        .op_load(op_load), .step_en(step_en), .hilo_we(hilo_we),
        .busy(busy), .stall_md(stall_md), .div0(div0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit dz;
    } exp_t;
    exp_t sb[$];

    int  n_vec = 0;
    int  n_err = 0;
    bit  done  = 1'b0;

    task automatic chk(input string name, input logic act, input logic req, input int t);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, t, act, req);
        end
    endtask

    // Monitor: every HI/LO write must match the oldest outstanding operation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc >= 3 && hilo_we === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_hilo_we cycle %0d: got hilo_we=1 expected none pending", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.due != cyc || div0 !== e.dz) begin
                        n_err++;
                        $display("FAIL hilo_we_timing cycle %0d: got div0=%b expected cycle %0d div0=%b",
                                 cyc, div0, e.due, e.dz);
                    end
                end
            end
        end
    end

    // Stimulus and timeline model: an operation accepted at cycle a with
    // run length n occupies cycles a+1..a+n+1, the last one being the write.
    initial begin
        int  t;
        int  m_acc = -10;
        int  m_end = -10;
        bit  m_dz  = 1'b0;
        bit  m_busy, acc, dz;
        int  n;
        exp_t keep[$];

        rst = 1'b1; start = 1'b0; mul0_div1_sel = 1'b0; opb_zero = 1'b0;
        hilo_rd = 1'b0; flushE = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < N_CYC + 60; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            t = cyc;
            if (i < N_CYC) begin
                rst           = ($urandom_range(0, 199) == 0);
                start         = ($urandom_range(0, 99) < 40);
                mul0_div1_sel = $urandom_range(0, 1);
                opb_zero      = $urandom_range(0, 1);
                hilo_rd       = ($urandom_range(0, 99) < 30);
                flushE        = ($urandom_range(0, 99) < 15);
            end else begin
                rst = 1'b0; start = 1'b0; hilo_rd = 1'b0; flushE = 1'b0;
            end
            @(negedge clk);

            m_busy = (t > m_acc) && (t <= m_end);
            acc    = !m_busy && start && !flushE && !rst;
            chk("busy",     busy,     m_busy, t);
            chk("op_load",  op_load,  acc, t);
            chk("step_en",  step_en,  m_busy && (t < m_end), t);
            chk("hilo_we",  hilo_we,  m_busy && (t == m_end), t);
            chk("stall_md", stall_md, m_busy && (hilo_rd || start), t);
            chk("div0",     div0,     m_busy && (t == m_end) && m_dz, t);

            if (rst) begin
                if (m_end > t) m_end = t;
                keep = {};
                foreach (sb[k]) if (sb[k].due <= t) keep.push_back(sb[k]);
                sb = keep;
            end else if (acc) begin
                dz    = FAST && mul0_div1_sel && opb_zero;
                n     = dz ? 0 : (mul0_div1_sel ? DIV_N : MUL_N);
                m_acc = t;
                m_end = t + n + 1;
                m_dz  = dz;
                sb.push_back('{due: m_end, dz: dz});
            end
        end

        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending operations expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter: MUL_CYCLES, 4, RUN-state cycles for multiply (legal range 1..63).
REQ-002 SHALL have parameter: DIV_CYCLES, 32, RUN-state cycles for divide (legal range 1..63).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: start  input  1  mult/div instruction present in Execute (muldiv_op qualified).
REQ-006 SHALL have port: mul0_div1_sel  input  1  operation select, sampled with start; 0 = mul, 1 = div.
REQ-007 SHALL have port: opb_zero  input  1  divisor operand equals zero, sampled with start.
REQ-008 SHALL have port: hilo_rd  input  1  mfhi/mflo present in Execute.
REQ-009 SHALL have port: flushE  input  1  Execute-stage flush; an instruction flushed this cycle SHALL NOT be accepted.
REQ-010 SHALL have port: op_load  output  1  one-cycle pulse; muldiv unit latches operands.
REQ-011 SHALL have port: step_en  output  1  iterative step enable for the muldiv unit.
REQ-012 SHALL have port: hilo_we  output  1  one-cycle HI/LO register write enable.
REQ-013 SHALL have port: busy  output  1  operation in progress (state != IDLE).
REQ-014 SHALL have port: stall_md  output  1  stall request to the hazard unit (freeze F/D/E).
REQ-015 SHALL have port: div0  output  1  divide-by-zero flag, valid with hilo_we.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 IDLE: start & !flushE SHALL assert op_load combinationally, latch op and load the counter with (MUL_CYCLES or DIV_CYCLES) - 1, and move to RUN.
REQ-018 RUN: step_en SHALL be 1; the counter SHALL decrement by one per cycle; at counter == 0 the state SHALL move to DONE.
REQ-019 DONE: hilo_we SHALL be 1 for exactly one cycle; the state SHALL then move to IDLE unconditionally.
REQ-020 Latency: start accepted in cycle t SHALL give hilo_we in cycle t+N+1, where N is the selected cycle count.
REQ-021 stall_md SHALL be busy & (hilo_rd | start); it SHALL be 0 in IDLE regardless of the inputs.
REQ-022 A start held during RUN/DONE SHALL be accepted in the first IDLE cycle if still asserted; it SHALL NOT be lost or double-accepted.
REQ-023 flushE SHALL NOT abort an operation already in RUN/DONE.
REQ-024 hilo_rd and start together in IDLE SHALL accept start and SHALL NOT stall.
REQ-025 The counter SHALL be 6 bits and SHALL never wrap; it is not decremented outside RUN.
REQ-026 op_load, step_en and hilo_we SHALL be mutually exclusive in every cycle.

Reset
REQ-027 rst SHALL force IDLE, counter 0 and latched op 0, and drive all outputs to 0 on the next edge, including mid-RUN and in DONE; no hilo_we SHALL follow.
REQ-028 rst SHALL take priority over start.

Configuration
REQ-029 With MULDIV_DIV0_FAST_EN defined: an accepted div with opb_zero = 1 SHALL go IDLE->DONE directly (hilo_we at t+1, no step_en), and div0 SHALL be 1 during that DONE cycle.
REQ-030 Without MULDIV_DIV0_FAST_EN: a divide by zero SHALL take the full DIV_CYCLES, and div0 SHALL be tied to 0.

Structure
REQ-031 Package muldiv_pkg SHALL hold the state encoding (2-bit), the counter width constant (6), and the default MUL_CYCLES/DIV_CYCLES values.
REQ-032 The controller SHALL be a single module with no sub-modules; the counter is inline.

Verification
REQ-033 rst, then start=1 with mul0_div1_sel=0 at t=0 -> op_load@0, step_en@1..4, hilo_we@5, busy@1..5.
REQ-034 start div at t=0, then hilo_rd=1 from t=3 -> stall_md@3..33, hilo_we@33, stall_md=0@34.
REQ-035 start mul at t=0, second start held high t=1..6 -> second op_load exactly once at t=6, second hilo_we at t=11.
REQ-036 start div at t=0, rst=1 at t=10 -> busy=0@11, no hilo_we through t=40.
REQ-037 MULDIV_DIV0_FAST_EN defined, start div with opb_zero=1 at t=0 -> hilo_we=1 and div0=1 at t=1, step_en never 1; macro undefined -> hilo_we@33, div0=0.
REQ-038 start=1 with flushE=1 in IDLE -> no op_load, busy stays 0.
